// File: rtl/audio_pkg.sv
// Shared definitions for the audio sample FIFO.
//   frame_bytes() - bytes per frame for a given sample width and channel count
//   play_state_e  - playback state (PRIME: buffering, PLAY: releasing frames)
//   SILENCE       - all-zero sample value, wide enough for any supported frame
package audio_pkg;

  typedef enum logic {
    PRIME = 1'b0,
    PLAY  = 1'b1
  } play_state_e;

  // Wide enough for the largest frame (32-bit stereo). Slice to the needed width.
  localparam logic [63:0] SILENCE = '0;

  function automatic int frame_bytes(input int sample_w, input int channels);
    return (sample_w / 8) * channels;
  endfunction

endpackage

// File: rtl/sample_packer.sv
// Assembles little-endian UART bytes into one audio frame.
// Byte k of a frame lands in frame bits [8k+7:8k], so the left (first) sample
// sits in the low SAMPLE_W bits and the right sample above it.
// Ports:
//   clk, rst       - clock, asynchronous active-high reset
//   flush_i        - synchronous clear of the byte counter; blocks the byte strobe
//   realign_i      - restart at a frame boundary (asserted when a frame is dropped)
//   byte_ready_i   - data_i is valid this cycle
//   data_i         - incoming byte
//   commit_o       - combinational: this cycle's byte completes frame_o
//   frame_o        - assembled frame, valid while commit_o is high
module sample_packer
  import audio_pkg::*;
#(
  parameter int SAMPLE_W = 16,
  parameter int CHANNELS = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush_i,
  input  logic                         realign_i,
  input  logic                         byte_ready_i,
  input  logic [7:0]                   data_i,
  output logic                         commit_o,
  output logic [SAMPLE_W*CHANNELS-1:0] frame_o
);

  localparam int FRAME_BYTES = frame_bytes(SAMPLE_W, CHANNELS);
  localparam int FRAME_BITS  = FRAME_BYTES * 8;
  localparam int CNT_W       = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_BYTES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_byte;

  assign last_byte = byte_ready_i && (cnt_q == LAST_IDX);
  assign commit_o  = last_byte && !flush_i;

  // NOTE: every variable assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (flush_i || realign_i) begin
      cnt_d = '0;
    end else if (byte_ready_i) begin
      cnt_d = last_byte ? '0 : cnt_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Only the first FRAME_BYTES-1 bytes need storing; the last byte is
  // taken straight from data_i so the frame commits on its own strobe edge.
  generate
    if (FRAME_BYTES == 1) begin : g_single
      assign frame_o = data_i;
    end else if (FRAME_BYTES == 2) begin : g_pair
      logic [7:0] shift_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          shift_q <= '0;
        end else if (byte_ready_i && !flush_i) begin
          shift_q <= data_i;
        end
      end
      assign frame_o = {data_i, shift_q};
    end else begin : g_wide
      logic [FRAME_BITS-9:0] shift_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          shift_q <= '0;
        end else if (byte_ready_i && !flush_i) begin
          shift_q <= {data_i, shift_q[FRAME_BITS-9:8]};
        end
      end
      assign frame_o = {data_i, shift_q};
    end
  endgenerate

endmodule

// File: rtl/audio_sample_fifo.sv
// Audio sample buffer between the UART byte receiver and the I2S transmitter.
// Bytes are packed into frames, buffered in a power-of-two FIFO, and one frame
// is released per sample_tick once START_LEVEL frames have been collected.
// Ports:
//   clk, rst                  - clock, asynchronous active-high reset
//   data_in, byte_ready       - UART byte and its one-cycle strobe
//   sample_tick               - one-cycle strobe at the I2S frame rate
//   flush                     - synchronous clear of all buffered data and state
//   left_sample, right_sample - current frame, held between ticks
//   sample_valid              - one-cycle pulse when the sample outputs update
//   level                     - frames stored, 0..DEPTH
//   playing                   - high while in PLAY
//   overflow, underrun        - sticky error flags, cleared by flush or reset
module audio_sample_fifo
  import audio_pkg::*;
#(
  parameter int SAMPLE_W      = 16,
  parameter int CHANNELS      = 2,
  parameter int DEPTH         = 512,
  parameter int START_LEVEL   = DEPTH / 2,
  parameter int UNDERRUN_HOLD = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               data_in,
  input  logic                     byte_ready,
  input  logic                     sample_tick,
  input  logic                     flush,
  output logic [SAMPLE_W-1:0]      left_sample,
  output logic [SAMPLE_W-1:0]      right_sample,
  output logic                     sample_valid,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     playing,
  output logic                     overflow,
  output logic                     underrun
);

  localparam int FRAME_BITS = frame_bytes(SAMPLE_W, CHANNELS) * 8;
  localparam int PTR_W      = $clog2(DEPTH);
  localparam int LVL_W      = PTR_W + 1;
  localparam logic [LVL_W-1:0] FULL_LEVEL  = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0] START_LVL   = LVL_W'(START_LEVEL);

  // Packer
  logic                  commit;
  logic [FRAME_BITS-1:0] frame;
  logic                  drop;

  sample_packer #(
    .SAMPLE_W (SAMPLE_W),
    .CHANNELS (CHANNELS)
  ) u_packer (
    .clk          (clk),
    .rst          (rst),
    .flush_i      (flush),
    .realign_i    (drop),
    .byte_ready_i (byte_ready),
    .data_i       (data_in),
    .commit_o     (commit),
    .frame_o      (frame)
  );

  // FIFO bookkeeping
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  play_state_e      state_q, state_d;

  logic tick;
  logic wr_en;
  logic pop;
  logic starve;

  // commit is already blocked by flush inside the packer.
  assign tick   = sample_tick && !flush;
  assign wr_en  = commit && (level_q != FULL_LEVEL);
  assign drop   = commit && (level_q == FULL_LEVEL);
  // Only the registered level is consulted: a frame committed this cycle
  // cannot be popped until the next one.
  assign pop    = tick && (state_q == PLAY) && (level_q != '0);
  assign starve = tick && (state_q == PLAY) && (level_q == '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    unique case ({wr_en, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end
  end

  // Playback state: leave PRIME once enough frames are buffered, fall back
  // to PRIME when a tick finds the FIFO empty.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      PRIME:   if (level_q >= START_LVL) state_d = PLAY;
      PLAY:    if (starve)               state_d = PRIME;
      default: state_d = PRIME;
    endcase
    if (flush) begin
      state_d = PRIME;
    end
  end

  // Output control. zero_q selects silence instead of the RAM read register,
  // so holding the last frame on underrun simply means leaving it untouched.
  logic zero_q, zero_d;
  logic valid_q, valid_d;
  logic ovf_q, ovf_d;
  logic und_q, und_d;

  always_comb begin
    zero_d  = zero_q;
    valid_d = 1'b0;
    ovf_d   = ovf_q | drop;
    und_d   = und_q | starve;
    if (tick) begin
      valid_d = 1'b1;
      if (state_q == PRIME) begin
        zero_d = 1'b1;
      end else if (pop) begin
        zero_d = 1'b0;
      end else if (UNDERRUN_HOLD == 0) begin
        zero_d = 1'b1;
      end
    end
    if (flush) begin
      zero_d  = 1'b1;
      valid_d = 1'b0;
      ovf_d   = 1'b0;
      und_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      state_q  <= PRIME;
      zero_q   <= 1'b1;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
      und_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      state_q  <= state_d;
      zero_q   <= zero_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
      und_q    <= und_d;
    end
  end

  // Frame storage: simple dual-port RAM with a registered read port.
  // A write never targets the slot being read: a pop needs level > 0 and a
  // write needs level < DEPTH, so the pointers differ whenever both happen.
  logic [FRAME_BITS-1:0] mem_q [DEPTH];
  logic [FRAME_BITS-1:0] rd_data_q;

  // NOTE: the RAM and its read register carry no reset so they map onto block RAM; zero_q masks the read register until a real pop.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= frame;
    end
    if (pop) begin
      rd_data_q <= mem_q[rd_ptr_q];
    end
  end

  assign left_sample = zero_q ? SILENCE[SAMPLE_W-1:0] : rd_data_q[SAMPLE_W-1:0];

  generate
    if (CHANNELS == 2) begin : g_stereo
      assign right_sample = zero_q ? SILENCE[SAMPLE_W-1:0]
                                   : rd_data_q[2*SAMPLE_W-1:SAMPLE_W];
    end else begin : g_mono
      assign right_sample = left_sample;
    end
  endgenerate

  assign sample_valid = valid_q;
  assign level        = level_q;
  assign playing      = (state_q == PLAY);
  assign overflow     = ovf_q;
  assign underrun     = und_q;

endmodule

// File: tb/tb_audio_sample_fifo.sv
// Self-checking bench for audio_sample_fifo.
// Main instance: 16-bit stereo, DEPTH=8, START_LEVEL=4, zero on underrun,
// checked every cycle against a queue-based reference model plus a vector
// table and directed sequences. Second instance: 8-bit mono, DEPTH=4,
// START_LEVEL=1, hold-last-frame on underrun, checked with directed values.
module tb_audio_sample_fifo;

  localparam int DEPTH = 8;
  localparam int START = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  data_in;
  logic        byte_ready;
  logic        sample_tick;
  logic        flush;
  logic [15:0] left_sample;
  logic [15:0] right_sample;
  logic        sample_valid;
  logic [3:0]  level;
  logic        playing;
  logic        overflow;
  logic        underrun;

  logic        rst_m;
  logic [7:0]  m_data;
  logic        m_byte;
  logic        m_tick;
  logic        m_flush;
  logic [7:0]  m_left;
  logic [7:0]  m_right;
  logic        m_valid;
  logic [2:0]  m_level;
  logic        m_playing;
  logic        m_ovf;
  logic        m_und;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  audio_sample_fifo #(
    .SAMPLE_W(16), .CHANNELS(2), .DEPTH(DEPTH), .START_LEVEL(START), .UNDERRUN_HOLD(0)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .data_in      (data_in),
    .byte_ready   (byte_ready),
    .sample_tick  (sample_tick),
    .flush        (flush),
    .left_sample  (left_sample),
    .right_sample (right_sample),
    .sample_valid (sample_valid),
    .level        (level),
    .playing      (playing),
    .overflow     (overflow),
    .underrun     (underrun)
  );

  audio_sample_fifo #(
    .SAMPLE_W(8), .CHANNELS(1), .DEPTH(4), .START_LEVEL(1), .UNDERRUN_HOLD(1)
  ) dut_mono (
    .clk          (clk),
    .rst          (rst_m),
    .data_in      (m_data),
    .byte_ready   (m_byte),
    .sample_tick  (m_tick),
    .flush        (m_flush),
    .left_sample  (m_left),
    .right_sample (m_right),
    .sample_valid (m_valid),
    .level        (m_level),
    .playing      (m_playing),
    .overflow     (m_ovf),
    .underrun     (m_und)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model (main instance) ----------------
  logic [31:0] fq[$];
  logic [7:0]  asm_b [4];
  int          bc;
  bit          mdl_play, mdl_ovf, mdl_und, mdl_valid;
  logic [15:0] mdl_left, mdl_right;

  task automatic model_reset();
    fq.delete();
    bc        = 0;
    mdl_play  = 0;
    mdl_ovf   = 0;
    mdl_und   = 0;
    mdl_valid = 0;
    mdl_left  = '0;
    mdl_right = '0;
  endtask

  // Advances the model by one clock using the inputs currently applied.
  task automatic model_step();
    int          lvl;
    bit          commit;
    bit          nplay;
    logic [31:0] fr;
    logic [31:0] out;
    if (flush) begin
      model_reset();
      return;
    end
    lvl    = fq.size();
    commit = 0;
    nplay  = mdl_play;
    fr     = '0;
    if (byte_ready) begin
      asm_b[bc] = data_in;
      bc++;
      if (bc == 4) begin
        commit = 1;
        bc     = 0;
        fr     = {asm_b[3], asm_b[2], asm_b[1], asm_b[0]};
      end
    end
    if (!mdl_play && lvl >= START) nplay = 1;
    mdl_valid = sample_tick;
    if (sample_tick) begin
      if (!mdl_play) begin
        mdl_left  = '0;
        mdl_right = '0;
      end else if (lvl > 0) begin
        out       = fq.pop_front();
        mdl_left  = out[15:0];
        mdl_right = out[31:16];
      end else begin
        mdl_und   = 1;
        mdl_left  = '0;
        mdl_right = '0;
        nplay     = 0;
      end
    end
    if (commit) begin
      if (lvl < DEPTH) fq.push_back(fr);
      else mdl_ovf = 1;
    end
    mdl_play = nplay;
  endtask

  task automatic check_model();
    check("level",        64'(level),        64'(fq.size()));
    check("playing",      64'(playing),      64'(mdl_play));
    check("sample_valid", 64'(sample_valid), 64'(mdl_valid));
    check("left_sample",  64'(left_sample),  64'(mdl_left));
    check("right_sample", 64'(right_sample), 64'(mdl_right));
    check("overflow",     64'(overflow),     64'(mdl_ovf));
    check("underrun",     64'(underrun),     64'(mdl_und));
  endtask

  // One clock on the main instance, then compare with the model.
  task automatic cycle(input logic br, input logic [7:0] d, input logic tk, input logic fl);
    byte_ready  = br;
    data_in     = d;
    sample_tick = tk;
    flush       = fl;
    model_step();
    @(posedge clk);
    #1;
    byte_ready  = 1'b0;
    sample_tick = 1'b0;
    flush       = 1'b0;
    check_model();
  endtask

  task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input logic [7:0] b3);
    cycle(1'b1, b0, 1'b0, 1'b0);
    cycle(1'b1, b1, 1'b0, 1'b0);
    cycle(1'b1, b2, 1'b0, 1'b0);
    cycle(1'b1, b3, 1'b0, 1'b0);
  endtask

  task automatic mcycle(input logic br, input logic [7:0] d, input logic tk);
    m_byte = br;
    m_data = d;
    m_tick = tk;
    @(posedge clk);
    #1;
    m_byte = 1'b0;
    m_tick = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        br;
    logic [7:0]  d;
    logic        tk;
    logic [3:0]  lvl;
    logic        play;
    logic        vld;
    logic [15:0] l;
    logic [15:0] r;
  } vec_t;

  vec_t vecs [19];

  initial begin
    rst = 1'b1; rst_m = 1'b1;
    data_in = '0; byte_ready = 1'b0; sample_tick = 1'b0; flush = 1'b0;
    m_data = '0; m_byte = 1'b0; m_tick = 1'b0; m_flush = 1'b0;
    model_reset();

    // Fill: 01,02,03,04 four times, wait a cycle for PLAY, one tick, one idle.
    for (int i = 0; i < 16; i++) begin
      vecs[i] = '{br: 1'b1, d: 8'((i % 4) + 1), tk: 1'b0, lvl: 4'((i + 1) / 4),
                  play: 1'b0, vld: 1'b0, l: 16'h0000, r: 16'h0000};
    end
    vecs[16] = '{br: 1'b0, d: 8'h00, tk: 1'b0, lvl: 4'd4, play: 1'b1, vld: 1'b0, l: 16'h0000, r: 16'h0000};
    vecs[17] = '{br: 1'b0, d: 8'h00, tk: 1'b1, lvl: 4'd3, play: 1'b1, vld: 1'b1, l: 16'h0201, r: 16'h0403};
    vecs[18] = '{br: 1'b0, d: 8'h00, tk: 1'b0, lvl: 4'd3, play: 1'b1, vld: 1'b0, l: 16'h0201, r: 16'h0403};

    #2;
    check("rst.left",     64'(left_sample),  64'h0);
    check("rst.right",    64'(right_sample), 64'h0);
    check("rst.level",    64'(level),        64'h0);
    check("rst.playing",  64'(playing),      64'h0);
    check("rst.valid",    64'(sample_valid), 64'h0);
    check("rst.overflow", 64'(overflow),     64'h0);
    check("rst.underrun", 64'(underrun),     64'h0);
    check("rst.m_left",   64'(m_left),       64'h0);
    #10;
    rst = 1'b0; rst_m = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 19; i++) begin
      cycle(vecs[i].br, vecs[i].d, vecs[i].tk, 1'b0);
      check($sformatf("vec%0d.level", i),   64'(level),        64'(vecs[i].lvl));
      check($sformatf("vec%0d.playing", i), 64'(playing),      64'(vecs[i].play));
      check($sformatf("vec%0d.valid", i),   64'(sample_valid), 64'(vecs[i].vld));
      check($sformatf("vec%0d.left", i),    64'(left_sample),  64'(vecs[i].l));
      check($sformatf("vec%0d.right", i),   64'(right_sample), 64'(vecs[i].r));
    end

    // Overflow: 9 frames into an empty 8-deep FIFO, then drain and underrun.
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    check("flush.level", 64'(level), 64'h0);
    for (int k = 1; k <= 9; k++) begin
      send_frame(8'(k), 8'(k + 16), 8'(k + 32), 8'(k + 48));
    end
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    check("ovf.level", 64'(level),    64'd8);
    check("ovf.flag",  64'(overflow), 64'h1);
    for (int k = 1; k <= 8; k++) begin
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
      check($sformatf("ovf.pop%0d.left", k),  64'(left_sample),  64'({8'(k + 16), 8'(k)}));
      check($sformatf("ovf.pop%0d.right", k), 64'(right_sample), 64'({8'(k + 48), 8'(k + 32)}));
    end
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    check("und.flag",    64'(underrun),     64'h1);
    check("und.left",    64'(left_sample),  64'h0);
    check("und.right",   64'(right_sample), 64'h0);
    check("und.valid",   64'(sample_valid), 64'h1);
    check("und.playing", 64'(playing),      64'h0);

    // Flush mid-frame, with a same-cycle byte strobe and tick that must be ignored.
    cycle(1'b1, 8'h11, 1'b0, 1'b0);
    cycle(1'b1, 8'h22, 1'b0, 1'b0);
    cycle(1'b1, 8'h33, 1'b0, 1'b0);
    cycle(1'b1, 8'h44, 1'b1, 1'b1);
    check("flush.ovf",   64'(overflow),     64'h0);
    check("flush.und",   64'(underrun),     64'h0);
    check("flush.valid", 64'(sample_valid), 64'h0);
    check("flush.lvl0",  64'(level),        64'h0);
    send_frame(8'hAA, 8'hBB, 8'hCC, 8'hDD);
    check("flush.lvl1",  64'(level),        64'h1);
    check("flush.ovf1",  64'(overflow),     64'h0);
    send_frame(8'h01, 8'h02, 8'h03, 8'h04);
    send_frame(8'h05, 8'h06, 8'h07, 8'h08);
    send_frame(8'h09, 8'h0A, 8'h0B, 8'h0C);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    check("flush.playing", 64'(playing), 64'h1);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    check("flush.left",  64'(left_sample),  64'hBBAA);
    check("flush.right", 64'(right_sample), 64'hDDCC);

    // Last byte of a frame and a tick in the same cycle at level 3.
    cycle(1'b1, 8'h5A, 1'b0, 1'b0);
    cycle(1'b1, 8'h5B, 1'b0, 1'b0);
    cycle(1'b1, 8'h5C, 1'b0, 1'b0);
    check("simul.before", 64'(level), 64'd3);
    cycle(1'b1, 8'h5D, 1'b1, 1'b0);
    check("simul.level", 64'(level),       64'd3);
    check("simul.left",  64'(left_sample), 64'h0201);

    // Randomised traffic in phases biased toward overflow, balance and underrun.
    for (int ph = 0; ph < 4; ph++) begin
      int pb, pt, pf;
      case (ph)
        0:       begin pb = 60; pt = 5;  pf = 0; end
        1:       begin pb = 50; pt = 12; pf = 2; end
        2:       begin pb = 20; pt = 30; pf = 0; end
        default: begin pb = 90; pt = 25; pf = 3; end
      endcase
      for (int n = 0; n < 700; n++) begin
        cycle(1'($urandom_range(0, 99) < pb), 8'($urandom),
              1'($urandom_range(0, 99) < pt), 1'($urandom_range(0, 999) < pf));
      end
    end

    // Mono 8-bit instance with hold-last-frame on underrun.
    mcycle(1'b0, 8'h00, 1'b1);
    check("mono.prime.valid", 64'(m_valid), 64'h1);
    check("mono.prime.left",  64'(m_left),  64'h0);
    mcycle(1'b1, 8'h7F, 1'b0);
    check("mono.level1",  64'(m_level),   64'h1);
    check("mono.prime",   64'(m_playing), 64'h0);
    mcycle(1'b0, 8'h00, 1'b0);
    check("mono.playing", 64'(m_playing), 64'h1);
    mcycle(1'b0, 8'h00, 1'b1);
    check("mono.left",  64'(m_left),  64'h7F);
    check("mono.right", 64'(m_right), 64'h7F);
    check("mono.valid", 64'(m_valid), 64'h1);
    check("mono.level0", 64'(m_level), 64'h0);
    mcycle(1'b0, 8'h00, 1'b1);
    check("mono.und.flag",    64'(m_und),     64'h1);
    check("mono.und.hold",    64'(m_left),    64'h7F);
    check("mono.und.holdr",   64'(m_right),   64'h7F);
    check("mono.und.playing", 64'(m_playing), 64'h0);
    check("mono.ovf",         64'(m_ovf),     64'h0);
    mcycle(1'b1, 8'h12, 1'b0);
    mcycle(1'b1, 8'h34, 1'b0);
    mcycle(1'b0, 8'h00, 1'b0);
    mcycle(1'b0, 8'h00, 1'b1);
    check("mono.second", 64'(m_left), 64'h12);
    #2;
    rst_m = 1'b1;
    #1;
    check("mono.rst.left",    64'(m_left),    64'h0);
    check("mono.rst.right",   64'(m_right),   64'h0);
    check("mono.rst.level",   64'(m_level),   64'h0);
    check("mono.rst.playing", 64'(m_playing), 64'h0);
    check("mono.rst.und",     64'(m_und),     64'h0);
    @(negedge clk);
    rst_m = 1'b0;
    mcycle(1'b0, 8'h00, 1'b0);
    check("mono.post.level", 64'(m_level), 64'h0);
    check("mono.post.left",  64'(m_left),  64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
